// File: rtl/accumulator_16_bit.sv
// accumulator_16_bit: 16-bit running-total accumulator fed by 8-bit operands
// over a valid/ready handshake. A single 8-bit ripple-carry adder is shared
// between the low-byte add and the high-byte carry add, with the carry held
// in a register between the two steps.
//
// Optional feature: define ACC_SATURATE_EN to clamp the total at 16'hFFFF
// instead of wrapping. Without it the total wraps modulo 2^16.

// Plain 8-bit ripple-carry adder, no carry-in, carry-out on c8.
module ripple_carry_adder_8_bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] sum,
  output logic       c8
);

  logic [8:0] carry;

  // Chain of full adders, carry rippling from bit 0 upward.
  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
    end
    c8 = carry[8];
  end

endmodule

module accumulator_16_bit #(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         din,
  output logic [15:0]        acc,
  output logic [COUNT_W-1:0] count,
  output logic               overflow,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADD_LO = 2'd1,
    ADD_HI = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        acc_q, acc_d;
  logic [7:0]         op_q, op_d;
  logic               carry_r_q, carry_r_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               overflow_q, overflow_d;

  logic [7:0]         adder_a;
  logic [7:0]         adder_b;
  logic [7:0]         adder_sum;
  logic               adder_c8;

  // Shared adder: low byte plus operand in ADD_LO, high byte plus the
  // registered carry in ADD_HI.
  always_comb begin
    adder_a = acc_q[7:0];
    adder_b = op_q;
    if (state_q == ADD_HI) begin
      adder_a = acc_q[15:8];
      adder_b = {7'b0, carry_r_q};
    end
  end

  ripple_carry_adder_8_bit u_adder (
    .a   (adder_a),
    .b   (adder_b),
    .sum (adder_sum),
    .c8  (adder_c8)
  );

  // Next-state logic: clear wins over everything, then the three-step
  // accept / low add / high add sequence.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    op_d       = op_q;
    carry_r_d  = carry_r_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (clr) begin
      state_d    = IDLE;
      acc_d      = 16'h0000;
      carry_r_d  = 1'b0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_d    = din;
            state_d = ADD_LO;
          end
        end
        ADD_LO: begin
          acc_d[7:0] = adder_sum;
          carry_r_d  = adder_c8;
          state_d    = ADD_HI;
        end
        ADD_HI: begin
          acc_d[15:8] = adder_sum;
          count_d     = count_q + COUNT_W'(1);
          if (adder_c8) begin
            overflow_d = 1'b1;
`ifdef ACC_SATURATE_EN
            acc_d      = 16'hFFFF;
`endif
          end
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers, asynchronously reset to an empty total.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= 16'h0000;
      op_q       <= 8'h00;
      carry_r_q  <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      op_q       <= op_d;
      carry_r_q  <= carry_r_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // An operand is only taken in IDLE, and never in a clearing cycle.
  always_comb begin
    in_ready = (state_q == IDLE) && !clr;
    busy     = (state_q != IDLE);
  end

  assign acc      = acc_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_accumulator_16_bit.sv
// Testbench for accumulator_16_bit: a cycle model predicts handshake and
// results; expected totals are queued on acceptance and compared when the
// operand finishes.
module tb_accumulator_16_bit;

   localparam int COUNT_W = 8;

   logic               clk;
   logic               rst_n;
   logic               clr;
   logic               in_valid;
   logic               in_ready;
   logic [7:0]         din;
   logic [15:0]        acc;
   logic [COUNT_W-1:0] count;
   logic               overflow;
   logic               busy;

   typedef struct {
      logic [15:0]        accExp;
      logic [COUNT_W-1:0] countExp;
      logic               ovfExp;
   } expEntry_t;

   expEntry_t sbQ[$];

   int checks = 0;
   int errors = 0;

   logic [15:0]        mAcc;
   logic [COUNT_W-1:0] mCount;
   logic               mOvf;
   int                 mPhase;
   logic               doneFlag;

   accumulator_16_bit #(.COUNT_W(COUNT_W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .din      (din),
      .acc      (acc),
      .count    (count),
      .overflow (overflow),
      .busy     (busy)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at time %0t", tag, actual, expected, $time);
      end
   endtask

   // Reference model of the handshake and arithmetic, advanced on each edge.
   always @(posedge clk or negedge rst_n) begin
      logic [16:0] sum17;
      expEntry_t   e;
      if (!rst_n) begin
         mAcc = 16'h0; mCount = '0; mOvf = 1'b0; mPhase = 0; doneFlag = 1'b0;
         sbQ.delete();
      end else if (clr) begin
         mAcc = 16'h0; mCount = '0; mOvf = 1'b0; mPhase = 0;
         sbQ.delete();
      end else begin
         case (mPhase)
            0: if (in_valid) begin
               sum17 = {1'b0, mAcc} + {9'b0, din};
               mOvf  = mOvf | sum17[16];
`ifdef ACC_SATURATE_EN
               mAcc  = sum17[16] ? 16'hFFFF : sum17[15:0];
`else
               mAcc  = sum17[15:0];
`endif
               mCount = mCount + COUNT_W'(1);
               e.accExp = mAcc; e.countExp = mCount; e.ovfExp = mOvf;
               sbQ.push_back(e);
               mPhase = 1;
            end
            1: mPhase = 2;
            default: begin
               mPhase = 0;
               doneFlag = 1'b1;
            end
         endcase
      end
   end

   // Monitor away from the edge: handshake each cycle, results on completion.
   always @(negedge clk) begin
      expEntry_t e;
      #1;
      if (rst_n) begin
         checkOutput("in_ready", 32'(in_ready), 32'((mPhase == 0) && !clr));
         checkOutput("busy", 32'(busy), 32'(mPhase != 0));
         if (doneFlag) begin
            doneFlag = 1'b0;
            checkOutput("sb_nonempty", 32'(sbQ.size() > 0), 32'd1);
            if (sbQ.size() > 0) begin
               e = sbQ.pop_front();
               checkOutput("sb_acc", 32'(acc), 32'(e.accExp));
               checkOutput("sb_count", 32'(count), 32'(e.countExp));
               checkOutput("sb_overflow", 32'(overflow), 32'(e.ovfExp));
            end
         end
      end
   end

   // Present one operand and hold it until the block takes it.
   task automatic applyStimulus(input logic [7:0] d);
      int guard = 0;
      @(negedge clk);
      din = d;
      in_valid = 1'b1;
      while (!in_ready && guard < 10) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("accept_wait", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic waitIdle();
      int guard = 0;
      @(negedge clk);
      #2;
      while (busy && guard < 10) begin
         @(negedge clk);
         #2;
         guard++;
      end
      checkOutput("idle_wait", 32'(busy), 32'd0);
   endtask

   task automatic clearBlock();
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
   endtask

   // Watchdog so the run always ends.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; din = 8'h00;
      #2;
      checkOutput("rst_acc", 32'(acc), 32'h0);
      checkOutput("rst_count", 32'(count), 32'h0);
      checkOutput("rst_overflow", 32'(overflow), 32'h0);
      checkOutput("rst_in_ready", 32'(in_ready), 32'h1);
      checkOutput("rst_busy", 32'(busy), 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Single add from zero.
      applyStimulus(8'h2A);
      waitIdle();
      checkOutput("single_acc", 32'(acc), 32'h002A);
      checkOutput("single_count", 32'(count), 32'h1);

      // Asynchronous reset while the low-byte add is in flight.
      @(negedge clk);
      din = 8'h10; in_valid = 1'b1;
      @(posedge clk);
      #2;
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_acc", 32'(acc), 32'h0);
      checkOutput("midrst_count", 32'(count), 32'h0);
      checkOutput("midrst_overflow", 32'(overflow), 32'h0);
      checkOutput("midrst_in_ready", 32'(in_ready), 32'h1);
      checkOutput("midrst_busy", 32'(busy), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Carry from low byte into high byte.
      applyStimulus(8'hFF);
      waitIdle();
      checkOutput("carry_pre_acc", 32'(acc), 32'h00FF);
      applyStimulus(8'h01);
      waitIdle();
      checkOutput("carry_acc", 32'(acc), 32'h0100);
      checkOutput("carry_overflow", 32'(overflow), 32'h0);

      // Back-to-back with in_valid held for 12 cycles.
      clearBlock();
      @(negedge clk);
      din = 8'h01; in_valid = 1'b1;
      repeat (12) @(negedge clk);
      in_valid = 1'b0;
      waitIdle();
      checkOutput("b2b_acc", 32'(acc), 32'h0004);
      checkOutput("b2b_count", 32'(count), 32'h4);

      // Clear during the high-byte add drops the operand.
      applyStimulus(8'h01);
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      #1;
      checkOutput("clr_acc", 32'(acc), 32'h0);
      checkOutput("clr_count", 32'(count), 32'h0);
      checkOutput("clr_busy", 32'(busy), 32'h0);

      // Preload to 16'hFFFF then push it over the top.
      for (int i = 0; i < 257; i++) applyStimulus(8'hFF);
      waitIdle();
      checkOutput("preload_acc", 32'(acc), 32'hFFFF);
      checkOutput("preload_overflow", 32'(overflow), 32'h0);
      applyStimulus(8'h01);
      waitIdle();
`ifdef ACC_SATURATE_EN
      checkOutput("ovf_acc", 32'(acc), 32'hFFFF);
`else
      checkOutput("ovf_acc", 32'(acc), 32'h0000);
`endif
      checkOutput("ovf_flag", 32'(overflow), 32'h1);

      // Count wraps after 256 zero operands; total is untouched.
      clearBlock();
      applyStimulus(8'h37);
      for (int i = 0; i < 256; i++) applyStimulus(8'h00);
      waitIdle();
      checkOutput("wrap_count", 32'(count), 32'h1);
      checkOutput("wrap_acc", 32'(acc), 32'h0037);
      checkOutput("wrap_overflow", 32'(overflow), 32'h0);

      repeat (3) @(negedge clk);
      checkOutput("sb_drained", 32'(sbQ.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
